// File: rtl/i2c_pkg.sv
//==============================================================================
// Module  : i2c_pkg
// Brief   : Shared types and constants for the I2C byte-level bit engine.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package i2c_pkg;

  // Command encoding carried on cmd_i
  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_READ  = 2'd3
  } cmd_t;

  // Engine state machine
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_STOP  = 3'd2,
    ST_BIT   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Quarter-period phase within one bus step
  typedef logic [1:0] phase_t;

  // Eight data bits plus the ACK/NACK bit
  localparam int unsigned BITS_PER_BYTE = 9;
  localparam logic [3:0]  LAST_BIT      = 4'(BITS_PER_BYTE - 1);

  // SDA pull-down for phase 0 of a data bit: data bits come from the shift
  // register MSB on WRITE, the ninth bit carries the master ACK/NACK on READ.
  function automatic logic bit_sda_oe(input cmd_t       cmd,
                                      input logic [3:0] bit_idx,
                                      input logic       data_msb,
                                      input logic       nack_send);
    logic oe;
    oe = 1'b0;
    if (bit_idx == LAST_BIT) begin
      if (cmd == CMD_READ) oe = ~nack_send;
    end else begin
      if (cmd == CMD_WRITE) oe = ~data_msb;
    end
    return oe;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_in_sync.sv
//==============================================================================
// Module  : i2c_in_sync
// Brief   : Multi-flop synchronizer for an asynchronous open-drain pad input.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module i2c_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the pad value through the chain; resets to the idle-bus level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/i2c_bit_engine.sv
//==============================================================================
// Module  : i2c_bit_engine
// Brief   : Executes START / STOP / WRITE / READ on open-drain SCL/SDA, paced
//           by a 4x-SCL-rate strobe. Returns read data and ACK status.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module i2c_bit_engine
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit STRETCH_EN  = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic [7:0] wdata_i,
  input  logic       nack_send_i,
  output logic       rsp_valid_o,
  output logic [7:0] rdata_o,
  output logic       nack_rcvd_o,
  output logic       busy_o,
  output logic       scl_oe_o,
  output logic       sda_oe_o,
  input  logic       scl_i,
  input  logic       sda_i
);

  state_t     state_q,     state_d;
  phase_t     phase_q,     phase_d;
  logic [3:0] bit_cnt_q,   bit_cnt_d;
  logic [7:0] shreg_q,     shreg_d;
  cmd_t       cmd_q,       cmd_d;
  logic       nack_send_q, nack_send_d;
  logic       ack_q,       ack_d;
  logic       scl_oe_q,    scl_oe_d;
  logic       sda_oe_q,    sda_oe_d;
  logic [7:0] rdata_q,     rdata_d;
  logic       nack_rcvd_q, nack_rcvd_d;

  logic scl_s;
  logic sda_s;
  logic step;

  i2c_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scl_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (scl_i),
    .q_o   (scl_s)
  );

  i2c_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sda_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (sda_i),
    .q_o   (sda_s)
  );

  // A tick ends the current phase unless SCL is released by us but a slave
  // is still holding it low (clock stretching); then the next tick retries.
  assign step = tick_i && !(STRETCH_EN && !scl_oe_q && !scl_s);

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      phase_q     <= 2'd0;
      bit_cnt_q   <= 4'd0;
      shreg_q     <= 8'd0;
      cmd_q       <= CMD_START;
      nack_send_q <= 1'b0;
      ack_q       <= 1'b0;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      rdata_q     <= 8'd0;
      nack_rcvd_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      cmd_q       <= cmd_d;
      nack_send_q <= nack_send_d;
      ack_q       <= ack_d;
      scl_oe_q    <= scl_oe_d;
      sda_oe_q    <= sda_oe_d;
      rdata_q     <= rdata_d;
      nack_rcvd_q <= nack_rcvd_d;
    end
  end

  // Next-state logic: line values for phase N are loaded on the tick ending
  // phase N-1 (phase 0 values are loaded on accept), so pads are registered.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    cmd_d       = cmd_q;
    nack_send_d = nack_send_q;
    ack_d       = ack_q;
    scl_oe_d    = scl_oe_q;
    sda_oe_d    = sda_oe_q;
    rdata_d     = rdata_q;
    nack_rcvd_d = nack_rcvd_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          cmd_d       = cmd_t'(cmd_i);
          nack_send_d = nack_send_i;
          shreg_d     = wdata_i;
          phase_d     = 2'd0;
          bit_cnt_d   = 4'd0;
          case (cmd_t'(cmd_i))
            CMD_START: begin
              state_d  = ST_START;
              sda_oe_d = 1'b0;
            end
            CMD_STOP: begin
              state_d  = ST_STOP;
              sda_oe_d = 1'b1;
            end
            default: begin
              state_d  = ST_BIT;
              scl_oe_d = 1'b1;
              sda_oe_d = bit_sda_oe(cmd_t'(cmd_i), 4'd0, wdata_i[7], nack_send_i);
            end
          endcase
        end
      end

      ST_START: begin
        if (step) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0:    scl_oe_d = 1'b0;
            2'd1:    sda_oe_d = 1'b1;
            2'd2:    scl_oe_d = 1'b1;
            default: state_d  = ST_DONE;
          endcase
        end
      end

      ST_STOP: begin
        if (step) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0:    scl_oe_d = 1'b0;
            2'd1:    sda_oe_d = 1'b0;
            2'd2:    begin end
            default: state_d  = ST_DONE;
          endcase
        end
      end

      ST_BIT: begin
        if (step) begin
          phase_d = phase_q + 2'd1;
          case (phase_q)
            2'd0: scl_oe_d = 1'b0;
            2'd1: begin end
            2'd2: begin
              // SCL has been high for a full phase: sample, then pull SCL low
              scl_oe_d = 1'b1;
              if (bit_cnt_q == LAST_BIT) ack_d = sda_s;
              else                       shreg_d = {shreg_q[6:0], sda_s};
            end
            default: begin
              if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = 4'd0;
                state_d   = ST_DONE;
                if (cmd_q == CMD_READ)  rdata_d     = shreg_q;
                if (cmd_q == CMD_WRITE) nack_rcvd_d = ack_q;
              end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                sda_oe_d  = bit_sda_oe(cmd_q, bit_cnt_q + 4'd1, shreg_q[7], nack_send_q);
              end
            end
          endcase
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign rsp_valid_o = (state_q == ST_DONE);
  assign rdata_o     = rdata_q;
  assign nack_rcvd_o = nack_rcvd_q;
  assign scl_oe_o    = scl_oe_q;
  assign sda_oe_o    = sda_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_bit_engine.sv
//==============================================================================
// Module  : tb_i2c_bit_engine
// Brief   : Directed self-checking bench with an open-drain slave model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_i2c_bit_engine;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic [7:0] wdata;
  logic       nack_send;
  wire        cmd_ready, rsp_valid, nack_rcvd, busy, scl_oe, sda_oe;
  wire  [7:0] rdata;

  logic bfm_scl_low = 1'b0;
  logic bfm_sda_low = 1'b0;
  wire  scl_bus = ~(scl_oe | bfm_scl_low);
  wire  sda_bus = ~(sda_oe | bfm_sda_low);

  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;
  int start_edges = 0;
  int stop_edges = 0;
  logic prev_scl = 1'b1;
  logic prev_sda = 1'b1;

  i2c_bit_engine #(.SYNC_STAGES(2), .STRETCH_EN(1'b1)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tick_i      (tick),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_i       (cmd),
    .wdata_i     (wdata),
    .nack_send_i (nack_send),
    .rsp_valid_o (rsp_valid),
    .rdata_o     (rdata),
    .nack_rcvd_o (nack_rcvd),
    .busy_o      (busy),
    .scl_oe_o    (scl_oe),
    .sda_oe_o    (sda_oe),
    .scl_i       (scl_bus),
    .sda_i       (sda_bus)
  );

  always #5 clk = ~clk;

  // Tick strobe every 10 clocks, one clock wide
  initial begin
    tick = 1'b0;
    forever begin
      repeat (9) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  // Bus monitor: response pulses and SDA edges while SCL stays high
  always begin
    @(posedge clk);
    #1;
    if (rsp_valid) rsp_cnt++;
    if (!rst && sda_bus !== prev_sda && scl_bus && prev_scl) begin
      if (!sda_bus) start_edges++;
      else          stop_edges++;
    end
    prev_scl = scl_bus;
    prev_sda = sda_bus;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_cmd(input logic [1:0] c, input logic [7:0] wd, input logic nk,
                        output int ticks);
    int n;
    ticks = 0;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_wait: ready=%b required 1", cmd_ready);
    end
    cmd = c; wdata = wd; nack_send = nk; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wdata = ~wd;
    nack_send = ~nk;
    for (n = 0; n < 3000; n++) begin
      @(posedge clk);
      if (tick) ticks++;
      #1;
      if (rsp_valid) break;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
    end
  endtask

  task automatic wait_scl(input logic v);
    int n;
    n = 0;
    while (scl_bus !== v && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (scl_bus !== v) begin
      checks++;
      errors++;
      $display("FAIL bfm_scl_wait: scl=%b required %b", scl_bus, v);
    end
  endtask

  // Slave model: mode 0 = write+ACK, 1 = write+NACK, 2 = read (sends data)
  task automatic bfm_run(input int mode, input logic [7:0] data, input int stretch_bit,
                         output logic [7:0] seen, output logic ninth, output logic ninth_oe);
    int n;
    seen = 8'h00; ninth = 1'bx; ninth_oe = 1'bx;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) bfm_sda_low = (mode == 2) ? ~data[7-k] : 1'b0;
      else       bfm_sda_low = (mode == 0);
      if (k == stretch_bit) begin
        n = 0;
        while (scl_oe !== 1'b0 && n < 2000) begin
          @(negedge clk);
          n++;
        end
        bfm_scl_low = 1'b1;
        repeat (25) @(negedge clk);
        bfm_scl_low = 1'b0;
      end
      wait_scl(1'b1);
      if (k < 8) seen[7-k] = sda_bus;
      else begin
        ninth = sda_bus;
        ninth_oe = sda_oe;
      end
      wait_scl(1'b0);
    end
    bfm_sda_low = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd = 2'd0; wdata = 8'd0; nack_send = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (scl_oe !== 1'b0)    begin errors++; $display("FAIL rst_scl_oe: got %b want 0", scl_oe); end
    checks++; if (sda_oe !== 1'b0)    begin errors++; $display("FAIL rst_sda_oe: got %b want 0", sda_oe); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp: got %b want 0", rsp_valid); end
    checks++; if (rdata !== 8'h00)    begin errors++; $display("FAIL rst_rdata: got %h want 00", rdata); end
    checks++; if (nack_rcvd !== 1'b0) begin errors++; $display("FAIL rst_nack: got %b want 0", nack_rcvd); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write_ack();
    int t, r0, s0, p0;
    logic [7:0] seen;
    logic nin, nin_oe;
    r0 = rsp_cnt; s0 = start_edges; p0 = stop_edges;
    do_cmd(CMD_START, 8'h00, 1'b0, t);
    checks++; if (t !== 4) begin errors++; $display("FAIL start_ticks: got %0d want 4", t); end
    fork
      do_cmd(CMD_WRITE, 8'hA5, 1'b0, t);
      bfm_run(0, 8'h00, -1, seen, nin, nin_oe);
    join
    checks++; if (t !== 36)        begin errors++; $display("FAIL wr_a5_ticks: got %0d want 36", t); end
    checks++; if (seen !== 8'hA5)  begin errors++; $display("FAIL wr_a5_serial: got %h want a5", seen); end
    checks++; if (nack_rcvd !== 1'b0) begin errors++; $display("FAIL wr_a5_nack: got %b want 0", nack_rcvd); end
    do_cmd(CMD_STOP, 8'h00, 1'b0, t);
    checks++; if (t !== 4) begin errors++; $display("FAIL stop_ticks: got %0d want 4", t); end
    @(negedge clk);
    checks++; if (rsp_cnt - r0 !== 3) begin errors++; $display("FAIL wr_rsp_count: got %0d want 3", rsp_cnt - r0); end
    checks++; if (start_edges - s0 !== 1) begin errors++; $display("FAIL wr_start_edges: got %0d want 1", start_edges - s0); end
    checks++; if (stop_edges - p0 !== 1)  begin errors++; $display("FAIL wr_stop_edges: got %0d want 1", stop_edges - p0); end
    checks++; if ({scl_oe, sda_oe} !== 2'b00) begin errors++; $display("FAIL stop_lines: got %b want 00", {scl_oe, sda_oe}); end
  endtask

  task automatic test_write_nack();
    int t;
    logic [7:0] seen;
    logic nin, nin_oe;
    do_cmd(CMD_START, 8'h00, 1'b0, t);
    fork
      do_cmd(CMD_WRITE, 8'h3C, 1'b0, t);
      bfm_run(1, 8'h00, -1, seen, nin, nin_oe);
    join
    checks++; if (t !== 36)           begin errors++; $display("FAIL wr_3c_ticks: got %0d want 36", t); end
    checks++; if (seen !== 8'h3C)     begin errors++; $display("FAIL wr_3c_serial: got %h want 3c", seen); end
    checks++; if (nack_rcvd !== 1'b1) begin errors++; $display("FAIL wr_3c_nack: got %b want 1", nack_rcvd); end
    do_cmd(CMD_STOP, 8'h00, 1'b0, t);
  endtask

  task automatic test_read_nack();
    int t;
    logic [7:0] seen;
    logic nin, nin_oe;
    do_cmd(CMD_START, 8'h00, 1'b0, t);
    fork
      do_cmd(CMD_READ, 8'h00, 1'b1, t);
      bfm_run(2, 8'hC3, -1, seen, nin, nin_oe);
    join
    checks++; if (t !== 36)        begin errors++; $display("FAIL rd_c3_ticks: got %0d want 36", t); end
    checks++; if (rdata !== 8'hC3) begin errors++; $display("FAIL rd_c3_data: got %h want c3", rdata); end
    checks++; if (nin !== 1'b1)    begin errors++; $display("FAIL rd_ninth_sda: got %b want 1", nin); end
    checks++; if (nin_oe !== 1'b0) begin errors++; $display("FAIL rd_ninth_oe: got %b want 0", nin_oe); end
    checks++; if (nack_rcvd !== 1'b1) begin errors++; $display("FAIL rd_nack_hold: got %b want 1", nack_rcvd); end
    do_cmd(CMD_STOP, 8'h00, 1'b0, t);
    checks++; if (rdata !== 8'hC3) begin errors++; $display("FAIL rd_data_hold: got %h want c3", rdata); end
  endtask

  task automatic test_stretch();
    int t;
    logic [7:0] seen;
    logic nin, nin_oe;
    do_cmd(CMD_START, 8'h00, 1'b0, t);
    fork
      do_cmd(CMD_WRITE, 8'h96, 1'b0, t);
      bfm_run(0, 8'h00, 3, seen, nin, nin_oe);
    join
    checks++; if (t !== 38)           begin errors++; $display("FAIL str_ticks: got %0d want 38", t); end
    checks++; if (seen !== 8'h96)     begin errors++; $display("FAIL str_serial: got %h want 96", seen); end
    checks++; if (nack_rcvd !== 1'b0) begin errors++; $display("FAIL str_nack: got %b want 0", nack_rcvd); end
    do_cmd(CMD_STOP, 8'h00, 1'b0, t);
  endtask

  task automatic test_repeated_start();
    int t, s0, p0;
    logic [7:0] seen;
    logic nin, nin_oe;
    s0 = start_edges; p0 = stop_edges;
    do_cmd(CMD_START, 8'h00, 1'b0, t);
    fork
      do_cmd(CMD_WRITE, 8'h50, 1'b0, t);
      bfm_run(0, 8'h00, -1, seen, nin, nin_oe);
    join
    checks++; if (seen !== 8'h50) begin errors++; $display("FAIL rs_wr_serial: got %h want 50", seen); end
    do_cmd(CMD_START, 8'h00, 1'b0, t);
    checks++; if (t !== 4) begin errors++; $display("FAIL rs_start_ticks: got %0d want 4", t); end
    fork
      do_cmd(CMD_READ, 8'h00, 1'b0, t);
      bfm_run(2, 8'h5A, -1, seen, nin, nin_oe);
    join
    checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL rs_rd_data: got %h want 5a", rdata); end
    checks++; if (nin !== 1'b0)    begin errors++; $display("FAIL rs_rd_ack: got %b want 0", nin); end
    checks++; if (start_edges - s0 !== 2) begin errors++; $display("FAIL rs_start_edges: got %0d want 2", start_edges - s0); end
    checks++; if (stop_edges - p0 !== 0)  begin errors++; $display("FAIL rs_stop_edges: got %0d want 0", stop_edges - p0); end
    do_cmd(CMD_STOP, 8'h00, 1'b0, t);
  endtask

  task automatic test_back_to_back();
    int n, r0, t;
    r0 = rsp_cnt;
    @(negedge clk);
    cmd = CMD_START; wdata = 8'h00; nack_send = 1'b0; cmd_valid = 1'b1;
    n = 0;
    while (n < 500) begin
      @(posedge clk);
      #1;
      if (rsp_valid) break;
      n++;
    end
    cmd_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rsp: got %b want 1", rsp_valid); end
    repeat (100) @(negedge clk);
    checks++; if (rsp_cnt - r0 !== 1) begin errors++; $display("FAIL b2b_accepts: got %0d want 1", rsp_cnt - r0); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", cmd_ready); end
    do_cmd(CMD_STOP, 8'h00, 1'b0, t);
  endtask

  task automatic test_reset_mid_write();
    int t, n, rel, r0;
    logic prev;
    do_cmd(CMD_START, 8'h00, 1'b0, t);
    @(negedge clk);
    cmd = CMD_WRITE; wdata = 8'h00; nack_send = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rel = 0; n = 0; prev = scl_oe;
    while (rel < 5 && n < 3000) begin
      @(negedge clk);
      if (prev && !scl_oe) rel++;
      prev = scl_oe;
      n++;
    end
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL mid_sda_oe: got %b want 1", sda_oe); end
    r0 = rsp_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (scl_oe !== 1'b0)    begin errors++; $display("FAIL abort_scl_oe: got %b want 0", scl_oe); end
    checks++; if (sda_oe !== 1'b0)    begin errors++; $display("FAIL abort_sda_oe: got %b want 0", sda_oe); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (rsp_cnt !== r0) begin errors++; $display("FAIL abort_no_rsp: got %0d pulses want 0", rsp_cnt - r0); end
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_write_nack();
    test_read_nack();
    test_stretch();
    test_repeated_start();
    test_back_to_back();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
